// File: rtl/receptor_serial.sv
// Serial frame receiver: start bit, five data bits, parity bit, stop bit.
// Data and received parity are presented in parallel with a one-cycle valido strobe.
module receptor_serial #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic B1,
  output logic B2,
  output logic B3,
  output logic B4,
  output logic B5,
  output logic bitparidade,
  output logic valido,
  output logic erro_quadro,
  output logic ocupado
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, entrada_s;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0]      shreg_q, shreg_d;
  logic [5:0]      dout_q, dout_d;
  logic            valido_q, valido_d;
  logic            erro_q, erro_d;
  logic            ocupado_q, ocupado_d;
  logic            tick;

  assign tick = (baud_q == '0);

  always_comb begin
    // NOTE: every signal gets its hold/default value first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    unique case (state_q)
      OCIOSO: begin
        if (!entrada_s) begin
          baud_d  = HALF_LOAD;
          state_d = INICIO;
        end
      end
      INICIO: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else if (!entrada_s) begin
          baud_d  = FULL_LOAD;
          idx_d   = '0;
          state_d = DADOS;
        end else begin
          state_d = OCIOSO;
        end
      end
      DADOS: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          // Shift right from the top so B1, the first bit on the line, ends in bit 0.
          shreg_d = {entrada_s, shreg_q[5:1]};
          baud_d  = FULL_LOAD;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd4) state_d = PARIDADE;
        end
      end
      PARIDADE: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          shreg_d = {entrada_s, shreg_q[5:1]};
          baud_d  = FULL_LOAD;
          state_d = PARADA;
        end
      end
      PARADA: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          if (entrada_s) begin
            dout_d   = shreg_q;
            valido_d = 1'b1;
          end else begin
            erro_d = 1'b1;
          end
          state_d = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
    ocupado_d = (state_d != OCIOSO);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1_q   <= 1'b1;
      entrada_s <= 1'b1;
      state_q   <= OCIOSO;
      baud_q    <= '0;
      idx_q     <= '0;
      // NOTE: the shift register is reset explicitly even though every frame overwrites it fully.
      shreg_q   <= '0;
      dout_q    <= '0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      sync1_q   <= entrada;
      entrada_s <= sync1_q;
      state_q   <= state_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      valido_q  <= valido_d;
      erro_q    <= erro_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign B1          = dout_q[0];
  assign B2          = dout_q[1];
  assign B3          = dout_q[2];
  assign B4          = dout_q[3];
  assign B5          = dout_q[4];
  assign bitparidade = dout_q[5];
  assign valido      = valido_q;
  assign erro_quadro = erro_q;
  assign ocupado     = ocupado_q;

endmodule
